// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED period controller and the blinker.
// Holds the debounce FSM state encoding, the default period limits that
// the blinker also relies on, and a helper that sizes the debounce counter.
package led_ctrl_pkg;

   // Default period limits, kept in one place so the blinker agrees with us
   localparam int unsigned DEF_PERIOD_W        = 8;
   localparam int unsigned DEF_MIN_PERIOD      = 1;
   localparam int unsigned DEF_MAX_PERIOD      = 141;
   localparam int unsigned DEF_INIT_PERIOD     = 10;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

   // Debounce FSM state encoding (plain constants so older tools accept them)
   typedef logic [1:0] db_state_t;
   localparam db_state_t DB_IDLE       = 2'd0;
   localparam db_state_t DB_PRESS_WAIT = 2'd1;
   localparam db_state_t DB_HELD       = 2'd2;
   localparam db_state_t DB_REL_WAIT   = 2'd3;

   // Counter width able to hold the value n itself (n >= 1)
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = $clog2(n + 1);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Per-button front end: two-flop synchroniser followed by a debounce FSM.
// A level is only accepted after DEBOUNCE_CYCLES consecutive identical
// synchronised samples. Each accepted press produces one registered
// single-cycle press_evt_o; holding the button never repeats the event.
module btn_debounce
   import led_ctrl_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic btn_i,
   output logic press_evt_o
);

   localparam int unsigned       CNT_W  = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  DC_VAL = CNT_W'(DEBOUNCE_CYCLES);

   logic [1:0]       sync_q;
   logic             btnSync;
   db_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cntInc;
   logic             evt_q, evt_d;

   // Two-flop synchroniser; the raw button is asynchronous to clk
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], btn_i};
      end
   end

   assign btnSync = sync_q[1];

   // The count always holds "samples accepted so far", so the sample taken
   // on this edge makes it cntInc; IDLE and HELD keep the count at zero, which
   // lets them share the waiting-state logic with PRESS_WAIT and REL_WAIT
   assign cntInc = cnt_q + CNT_W'(1);

   // Debounce FSM: wait for a stable press, report it once, wait for a stable release
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      evt_d   = 1'b0;
      case (state_q)
         DB_IDLE, DB_PRESS_WAIT: begin
            if (!btnSync) begin
               state_d = DB_IDLE;
               cnt_d   = '0;
            end else if (cntInc == DC_VAL) begin
               state_d = DB_HELD;
               cnt_d   = '0;
               evt_d   = 1'b1;
            end else begin
               state_d = DB_PRESS_WAIT;
               cnt_d   = cntInc;
            end
         end
         DB_HELD, DB_REL_WAIT: begin
            if (btnSync) begin
               state_d = DB_HELD;
               cnt_d   = '0;
            end else if (cntInc == DC_VAL) begin
               state_d = DB_IDLE;
               cnt_d   = '0;
            end else begin
               state_d = DB_REL_WAIT;
               cnt_d   = cntInc;
            end
         end
         default: begin
            state_d = DB_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM state, stability counter and the registered press event
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= DB_IDLE;
         cnt_q   <= '0;
         evt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         evt_q   <= evt_d;
      end
   end

   assign press_evt_o = evt_q;

endmodule

// File: rtl/led_period_ctrl.sv
// Upstream stage of the LED blinker. Two debounced push-buttons step the
// blink period up or down by one within [MIN_PERIOD, MAX_PERIOD]. Every
// period change produces a one-cycle period_update pulse, mirrored on
// blink_restart so the blinker restarts its count with the new period.
// blink_restart is also held high through reset and the first edge after it.
// Build option: define PERIOD_WRAP_EN to wrap around at the limits
// (MAX -> MIN on up, MIN -> MAX on down) instead of saturating.
module led_period_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int unsigned PERIOD_W        = DEF_PERIOD_W,
   parameter int unsigned MIN_PERIOD      = DEF_MIN_PERIOD,
   parameter int unsigned MAX_PERIOD      = DEF_MAX_PERIOD,
   parameter int unsigned INIT_PERIOD     = DEF_INIT_PERIOD,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
)
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                btn_up,
   input  logic                btn_down,
   output logic [PERIOD_W-1:0] period,
   output logic                period_update,
   output logic                blink_restart
);

   // One extra bit so +1 at the top of the range cannot silently overflow
   localparam int unsigned         EXT_W  = PERIOD_W + 1;
   localparam logic [EXT_W-1:0]    MIN_X  = EXT_W'(MIN_PERIOD);
   localparam logic [EXT_W-1:0]    MAX_X  = EXT_W'(MAX_PERIOD);
   localparam logic [PERIOD_W-1:0] INIT_P = PERIOD_W'(INIT_PERIOD);

   logic                upEvt, downEvt;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                upd_q, upd_d;
   logic                restart_q;
   logic [EXT_W-1:0]    periodExt, incVal, decVal;

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce_up (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_i       (btn_up),
      .press_evt_o (upEvt)
   );

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce_down (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_i       (btn_down),
      .press_evt_o (downEvt)
   );

   // Next period: step on a lone up/down event, saturate or wrap at the limits;
   // simultaneous up and down cancel each other
   always_comb begin
      periodExt = {1'b0, period_q};
      incVal    = periodExt + EXT_W'(1);
      decVal    = periodExt - EXT_W'(1);
      period_d  = period_q;
      upd_d     = 1'b0;
      if (upEvt && !downEvt) begin
         if (incVal > MAX_X) begin
`ifdef PERIOD_WRAP_EN
            period_d = MIN_X[PERIOD_W-1:0];
            upd_d    = 1'b1;
`else
            period_d = period_q;
            upd_d    = 1'b0;
`endif
         end else begin
            period_d = incVal[PERIOD_W-1:0];
            upd_d    = 1'b1;
         end
      end else if (downEvt && !upEvt) begin
         if (decVal[PERIOD_W] || (decVal < MIN_X)) begin
`ifdef PERIOD_WRAP_EN
            period_d = MAX_X[PERIOD_W-1:0];
            upd_d    = 1'b1;
`else
            period_d = period_q;
            upd_d    = 1'b0;
`endif
         end else begin
            period_d = decVal[PERIOD_W-1:0];
            upd_d    = 1'b1;
         end
      end
   end

   // Period register plus the update/restart pulses; restart starts high so the
   // blinker sees a restart on the first edge after reset is released
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_q  <= INIT_P;
         upd_q     <= 1'b0;
         restart_q <= 1'b1;
      end else begin
         period_q  <= period_d;
         upd_q     <= upd_d;
         restart_q <= upd_d;
      end
   end

   assign period        = period_q;
   assign period_update = upd_q;
   assign blink_restart = restart_q;

endmodule

// File: tb/tb_led_period_ctrl.sv
// Scoreboard bench for led_period_ctrl. Stimulus pushes the expected new
// period and the edge on which it must appear; a monitor on the falling
// edge pops and compares whenever an update is due, and flags any pulse
// that was not predicted.
`timescale 1ns/1ps
module tb_led_period_ctrl;

   localparam int PERIOD_W = 8;
   localparam int MIN_P    = 1;
   localparam int MAX_P    = 141;
   localparam int INIT_P   = 10;
   localparam int DC       = 4;

   logic                clk      = 1'b0;
   logic                reset_n  = 1'b0;
   logic                btn_up   = 1'b0;
   logic                btn_down = 1'b0;
   logic [PERIOD_W-1:0] period;
   logic                period_update;
   logic                blink_restart;

   typedef struct {
      int expPeriod;
      int expCycle;
   } exp_t;

   exp_t sbQueue[$];
   int   cyc         = 0;
   int   relEdges    = 0;
   int   assertions  = 0;
   int   failures    = 0;
   int   modelPeriod = INIT_P;
   int   monPeriod   = INIT_P;

   led_period_ctrl #(
      .PERIOD_W        (PERIOD_W),
      .MIN_PERIOD      (MIN_P),
      .MAX_PERIOD      (MAX_P),
      .INIT_PERIOD     (INIT_P),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .btn_up        (btn_up),
      .btn_down      (btn_down),
      .period        (period),
      .period_update (period_update),
      .blink_restart (blink_restart)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Edge counter used to time-stamp expected updates
   always @(posedge clk) cyc <= cyc + 1;

   // Edges seen since the last reset release
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) relEdges <= 0;
      else if (relEdges < 1000) relEdges <= relEdges + 1;
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference step model: pushes the expected period and update edge
   task automatic predictStep(input bit up, input bit down);
      int  nxt;
      bit  chg;
      nxt = modelPeriod;
      chg = 1'b0;
      if (up && !down) begin
         if (modelPeriod == MAX_P) begin
`ifdef PERIOD_WRAP_EN
            nxt = MIN_P;
            chg = 1'b1;
`endif
         end else begin
            nxt = modelPeriod + 1;
            chg = 1'b1;
         end
      end else if (down && !up) begin
         if (modelPeriod == MIN_P) begin
`ifdef PERIOD_WRAP_EN
            nxt = MAX_P;
            chg = 1'b1;
`endif
         end else begin
            nxt = modelPeriod - 1;
            chg = 1'b1;
         end
      end
      if (chg) begin
         modelPeriod = nxt;
         // Driven now, first sampled on edge cyc+1, visible on edge cyc+1+2+DC
         sbQueue.push_back('{nxt, cyc + 3 + DC});
      end
   endtask

   // One button press: optional 1,0,1,0 bounce, stable level for 'hold' cycles, release
   task automatic applyStimulus(input bit up, input bit down, input int hold, input bit bounce);
      @(negedge clk);
      if (bounce) begin
         for (int i = 0; i < 4; i++) begin
            btn_up = (i % 2 == 0);
            @(negedge clk);
         end
      end
      predictStep(up, down);
      btn_up   = up;
      btn_down = down;
      repeat (hold) @(negedge clk);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      repeat (DC + 6) @(negedge clk);
   endtask

   // Monitor: compares pulses and period against the scoreboard every cycle
   always @(negedge clk) begin : monitorBlk
      bit   expUpd;
      exp_t head;
      if (!reset_n) begin
         monPeriod = INIT_P;
      end else if (relEdges >= 1) begin
         expUpd = (sbQueue.size() > 0) && (sbQueue[0].expCycle == cyc);
         checkOutput("period_update", int'(period_update), int'(expUpd));
         checkOutput("blink_restart", int'(blink_restart), int'(expUpd));
         if (expUpd) begin
            head      = sbQueue.pop_front();
            monPeriod = head.expPeriod;
         end
         checkOutput("period_value", int'(period), monPeriod);
      end
   end

   // Hard time limit so the bench can never hang
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached, %0d updates still pending", sbQueue.size());
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_period", int'(period), 10);
      checkOutput("reset_update", int'(period_update), 0);
      checkOutput("reset_restart", int'(blink_restart), 1);
      #2 reset_n = 1'b1;
      #1;
      checkOutput("release_restart_before_edge", int'(blink_restart), 1);
      @(posedge clk);
      #1;
      checkOutput("restart_after_first_edge", int'(blink_restart), 0);
      checkOutput("period_after_release", int'(period), 10);

      // Idle: no pulses expected
      repeat (10) @(negedge clk);

      // Clean press held 20 cycles: 10 -> 11
      applyStimulus(1'b1, 1'b0, 20, 1'b0);
      checkOutput("clean_up_press", int'(period), 11);

      // Bouncy press: single increment 11 -> 12
      applyStimulus(1'b1, 1'b0, DC + 3, 1'b1);
      checkOutput("bounce_up_press", int'(period), 12);

      // Down press: 12 -> 11
      applyStimulus(1'b0, 1'b1, DC + 3, 1'b0);
      checkOutput("down_press", int'(period), 11);

      // Both buttons together: no change
      applyStimulus(1'b1, 1'b1, DC + 3, 1'b0);
      checkOutput("both_pressed", int'(period), 11);

      // Climb to the upper limit, then one more up press
      while (modelPeriod < MAX_P) applyStimulus(1'b1, 1'b0, DC + 3, 1'b0);
      checkOutput("reached_max", int'(period), 141);
      applyStimulus(1'b1, 1'b0, DC + 3, 1'b0);
`ifdef PERIOD_WRAP_EN
      checkOutput("up_at_max", int'(period), 1);
`else
      checkOutput("up_at_max", int'(period), 141);
`endif

      // Descend to the lower limit, then one more down press
      while (modelPeriod > MIN_P) applyStimulus(1'b0, 1'b1, DC + 3, 1'b0);
      checkOutput("reached_min", int'(period), 1);
      applyStimulus(1'b0, 1'b1, DC + 3, 1'b0);
`ifdef PERIOD_WRAP_EN
      checkOutput("down_at_min", int'(period), 141);
`else
      checkOutput("down_at_min", int'(period), 1);
`endif

      // Reset while the up debouncer is in PRESS_WAIT, button kept held
      @(negedge clk);
      btn_up = 1'b1;
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      modelPeriod = INIT_P;
      #1;
      checkOutput("midpress_reset_period", int'(period), 10);
      checkOutput("midpress_reset_update", int'(period_update), 0);
      checkOutput("midpress_reset_restart", int'(blink_restart), 1);
      @(negedge clk);
      #2 reset_n = 1'b1;
      predictStep(1'b1, 1'b0);
      repeat (DC + 4) @(negedge clk);
      btn_up = 1'b0;
      repeat (DC + 6) @(negedge clk);
      checkOutput("held_through_reset", int'(period), 11);

      // Drain any outstanding expectations (bounded)
      for (int i = 0; i < 50 && sbQueue.size() > 0; i++) @(negedge clk);
      checkOutput("scoreboard_drained", sbQueue.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
